// File: rtl/multi_sync_filter_if.sv
// Level-signal bundle between an asynchronous source and multi_sync_filter.
// master drives the raw levels, slave returns the synchronised, filtered and edge views.
interface multi_sync_filter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] i_data;
    logic [WIDTH-1:0] o_sync;
    logic [WIDTH-1:0] o_filt;
    logic [WIDTH-1:0] o_rise;
    logic [WIDTH-1:0] o_fall;

    modport master (
        output i_data,
        input  o_sync,
        input  o_filt,
        input  o_rise,
        input  o_fall
    );

    modport slave (
        input  i_data,
        output o_sync,
        output o_filt,
        output o_rise,
        output o_fall
    );
endinterface

// File: rtl/multi_sync_filter.sv
// Per-channel synchroniser, deglitch filter and registered edge pulses for slow async levels.
// Latency: o_sync STAGES edges, o_filt/o_rise/o_fall STAGES+FILTER_LEN edges; no backpressure.
module multi_sync_filter #(
    parameter int               WIDTH      = 4,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}}
) (
    input logic               i_clk,
    input logic               i_rst_n,
    multi_sync_filter_if.slave bus
);

    localparam int             CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_w;
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= bus.i_data;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_w = sync_q[STAGES-1];

    always_comb begin
        filt_d = filt_q;
        for (int k = 0; k < WIDTH; k++) begin
            cnt_d[k] = '0;
            if (sync_w[k] != filt_q[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    filt_d[k] = sync_w[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
        end
        // Pulses follow only filter acceptance, so reset and its release never create one.
        rise_d = filt_d & ~filt_q;
        fall_d = ~filt_d & filt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            filt_q <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
            for (int k = 0; k < WIDTH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int k = 0; k < WIDTH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign bus.o_sync = sync_w;
    assign bus.o_filt = filt_q;
    assign bus.o_rise = rise_q;
    assign bus.o_fall = fall_q;

endmodule

// File: tb/tb_multi_sync_filter.sv
// Directed bench: default-parameter instance plus a STAGES=3, FILTER_LEN=1, RST_VAL=F instance.
module tb_multi_sync_filter;

    logic clk;
    logic rst1_n;
    logic rst2_n;
    int   errors = 0;
    int   checks = 0;

    multi_sync_filter_if #(.WIDTH(4)) bus1 ();
    multi_sync_filter_if #(.WIDTH(4)) bus2 ();

    multi_sync_filter #(
        .WIDTH(4), .STAGES(2), .FILTER_LEN(4), .RST_VAL(4'h0)
    ) dut1 (
        .i_clk  (clk),
        .i_rst_n(rst1_n),
        .bus    (bus1)
    );

    multi_sync_filter #(
        .WIDTH(4), .STAGES(3), .FILTER_LEN(1), .RST_VAL(4'hF)
    ) dut2 (
        .i_clk  (clk),
        .i_rst_n(rst2_n),
        .bus    (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] d);
        rst1_n = 1'b0;
        bus1.i_data = d;
        tick();
        tick();
        rst1_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst1_n = 1'b0;
        bus1.i_data = 4'hA;
        repeat (3) tick();
        checks++; if (bus1.o_sync !== 4'h0) begin errors++; $display("FAIL rst_sync: got %h expected %h", bus1.o_sync, 4'h0); end
        checks++; if (bus1.o_filt !== 4'h0) begin errors++; $display("FAIL rst_filt: got %h expected %h", bus1.o_filt, 4'h0); end
        checks++; if ((bus1.o_rise | bus1.o_fall) !== 4'h0) begin errors++; $display("FAIL rst_pulses: got rise=%h fall=%h expected 0", bus1.o_rise, bus1.o_fall); end
        rst1_n = 1'b1;
        tick();
        checks++; if (bus1.o_sync !== 4'h0) begin errors++; $display("FAIL rel_sync_e1: got %h expected %h", bus1.o_sync, 4'h0); end
        tick();
        checks++; if (bus1.o_sync !== 4'hA) begin errors++; $display("FAIL rel_sync_e2: got %h expected %h", bus1.o_sync, 4'hA); end
        repeat (3) tick();
        checks++; if (bus1.o_filt !== 4'h0) begin errors++; $display("FAIL rel_filt_e5: got %h expected %h", bus1.o_filt, 4'h0); end
        checks++; if (bus1.o_rise !== 4'h0) begin errors++; $display("FAIL rel_rise_e5: got %h expected %h", bus1.o_rise, 4'h0); end
        tick();
        checks++; if (bus1.o_filt !== 4'hA) begin errors++; $display("FAIL rel_filt_e6: got %h expected %h", bus1.o_filt, 4'hA); end
        checks++; if (bus1.o_rise !== 4'hA) begin errors++; $display("FAIL rel_rise_e6: got %h expected %h", bus1.o_rise, 4'hA); end
        checks++; if (bus1.o_fall !== 4'h0) begin errors++; $display("FAIL rel_fall_e6: got %h expected %h", bus1.o_fall, 4'h0); end
        tick();
        checks++; if (bus1.o_rise !== 4'h0) begin errors++; $display("FAIL rel_rise_e7: got %h expected %h", bus1.o_rise, 4'h0); end
        checks++; if (bus1.o_filt !== 4'hA) begin errors++; $display("FAIL rel_filt_e7: got %h expected %h", bus1.o_filt, 4'hA); end
    endtask

    task automatic test_both_edges();
        bus1.i_data = 4'h5;
        repeat (5) tick();
        checks++; if (bus1.o_filt !== 4'hA) begin errors++; $display("FAIL both_filt_e5: got %h expected %h", bus1.o_filt, 4'hA); end
        tick();
        checks++; if (bus1.o_filt !== 4'h5) begin errors++; $display("FAIL both_filt_e6: got %h expected %h", bus1.o_filt, 4'h5); end
        checks++; if (bus1.o_rise !== 4'h5) begin errors++; $display("FAIL both_rise_e6: got %h expected %h", bus1.o_rise, 4'h5); end
        checks++; if (bus1.o_fall !== 4'hA) begin errors++; $display("FAIL both_fall_e6: got %h expected %h", bus1.o_fall, 4'hA); end
        tick();
        checks++; if ((bus1.o_rise | bus1.o_fall) !== 4'h0) begin errors++; $display("FAIL both_pulses_e7: got rise=%h fall=%h expected 0", bus1.o_rise, bus1.o_fall); end
    endtask

    task automatic test_rise();
        do_reset(4'h0);
        bus1.i_data = 4'h1;
        tick();
        checks++; if (bus1.o_sync !== 4'h0) begin errors++; $display("FAIL rise_sync_e1: got %h expected %h", bus1.o_sync, 4'h0); end
        tick();
        checks++; if (bus1.o_sync !== 4'h1) begin errors++; $display("FAIL rise_sync_e2: got %h expected %h", bus1.o_sync, 4'h1); end
        repeat (3) tick();
        checks++; if (bus1.o_filt !== 4'h0) begin errors++; $display("FAIL rise_filt_e5: got %h expected %h", bus1.o_filt, 4'h0); end
        tick();
        checks++; if (bus1.o_filt !== 4'h1) begin errors++; $display("FAIL rise_filt_e6: got %h expected %h", bus1.o_filt, 4'h1); end
        checks++; if (bus1.o_rise !== 4'h1) begin errors++; $display("FAIL rise_rise_e6: got %h expected %h", bus1.o_rise, 4'h1); end
        tick();
        checks++; if (bus1.o_rise !== 4'h0) begin errors++; $display("FAIL rise_rise_e7: got %h expected %h", bus1.o_rise, 4'h0); end
    endtask

    task automatic test_glitch();
        int         pw    = 0;
        int         first = -1;
        logic [3:0] bad   = 4'h0;
        do_reset(4'h0);
        bus1.i_data = 4'h2;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 3) bus1.i_data = 4'h0;
            if (bus1.o_sync[1]) begin
                pw++;
                if (first < 0) first = i;
            end
            bad = bad | bus1.o_filt | bus1.o_rise | bus1.o_fall;
        end
        checks++; if (pw !== 3) begin errors++; $display("FAIL glitch_sync_width: got %0d expected %0d", pw, 3); end
        checks++; if (first !== 2) begin errors++; $display("FAIL glitch_sync_start: got edge %0d expected edge %0d", first, 2); end
        checks++; if (bad !== 4'h0) begin errors++; $display("FAIL glitch_leak: got %h expected %h", bad, 4'h0); end
    endtask

    task automatic test_toggle();
        logic [3:0] bad = 4'h0;
        do_reset(4'h0);
        for (int i = 0; i < 30; i++) begin
            bus1.i_data = ((i / 3) % 2 == 0) ? 4'h8 : 4'h0;
            tick();
            bad = bad | bus1.o_filt | bus1.o_rise | bus1.o_fall;
        end
        checks++; if (bad !== 4'h0) begin errors++; $display("FAIL toggle_leak: got %h expected %h", bad, 4'h0); end
        bus1.i_data = 4'h8;
        repeat (6) tick();
        checks++; if (bus1.o_filt !== 4'h8) begin errors++; $display("FAIL toggle_settle: got %h expected %h", bus1.o_filt, 4'h8); end
    endtask

    task automatic test_reset_mid();
        do_reset(4'h0);
        bus1.i_data = 4'h4;
        tick();
        tick();
        checks++; if (bus1.o_sync !== 4'h4) begin errors++; $display("FAIL mid_sync_e2: got %h expected %h", bus1.o_sync, 4'h4); end
        tick();
        tick();
        rst1_n = 1'b0;
        #1;
        checks++; if (bus1.o_sync !== 4'h0) begin errors++; $display("FAIL mid_async_sync: got %h expected %h", bus1.o_sync, 4'h0); end
        checks++; if ((bus1.o_filt | bus1.o_rise | bus1.o_fall) !== 4'h0) begin errors++; $display("FAIL mid_async_outs: got filt=%h rise=%h fall=%h expected 0", bus1.o_filt, bus1.o_rise, bus1.o_fall); end
        tick();
        tick();
        rst1_n = 1'b1;
        tick();
        checks++; if (bus1.o_sync !== 4'h0) begin errors++; $display("FAIL mid_sync_e1: got %h expected %h", bus1.o_sync, 4'h0); end
        tick();
        checks++; if (bus1.o_sync !== 4'h4) begin errors++; $display("FAIL mid_sync_r2: got %h expected %h", bus1.o_sync, 4'h4); end
        repeat (3) tick();
        checks++; if (bus1.o_filt !== 4'h0) begin errors++; $display("FAIL mid_filt_e5: got %h expected %h", bus1.o_filt, 4'h0); end
        tick();
        checks++; if (bus1.o_filt !== 4'h4) begin errors++; $display("FAIL mid_filt_e6: got %h expected %h", bus1.o_filt, 4'h4); end
        checks++; if (bus1.o_rise !== 4'h4) begin errors++; $display("FAIL mid_rise_e6: got %h expected %h", bus1.o_rise, 4'h4); end
    endtask

    task automatic test_params();
        checks++; if (bus2.o_sync !== 4'hF) begin errors++; $display("FAIL p_rst_sync: got %h expected %h", bus2.o_sync, 4'hF); end
        checks++; if (bus2.o_filt !== 4'hF) begin errors++; $display("FAIL p_rst_filt: got %h expected %h", bus2.o_filt, 4'hF); end
        checks++; if ((bus2.o_rise | bus2.o_fall) !== 4'h0) begin errors++; $display("FAIL p_rst_pulses: got rise=%h fall=%h expected 0", bus2.o_rise, bus2.o_fall); end
        rst2_n = 1'b1;
        tick();
        tick();
        checks++; if (bus2.o_sync !== 4'hF) begin errors++; $display("FAIL p_sync_e2: got %h expected %h", bus2.o_sync, 4'hF); end
        checks++; if (bus2.o_fall !== 4'h0) begin errors++; $display("FAIL p_fall_e2: got %h expected %h", bus2.o_fall, 4'h0); end
        tick();
        checks++; if (bus2.o_sync !== 4'h0) begin errors++; $display("FAIL p_sync_e3: got %h expected %h", bus2.o_sync, 4'h0); end
        checks++; if (bus2.o_filt !== 4'hF) begin errors++; $display("FAIL p_filt_e3: got %h expected %h", bus2.o_filt, 4'hF); end
        tick();
        checks++; if (bus2.o_filt !== 4'h0) begin errors++; $display("FAIL p_filt_e4: got %h expected %h", bus2.o_filt, 4'h0); end
        checks++; if (bus2.o_fall !== 4'hF) begin errors++; $display("FAIL p_fall_e4: got %h expected %h", bus2.o_fall, 4'hF); end
        checks++; if (bus2.o_rise !== 4'h0) begin errors++; $display("FAIL p_rise_e4: got %h expected %h", bus2.o_rise, 4'h0); end
        tick();
        checks++; if (bus2.o_fall !== 4'h0) begin errors++; $display("FAIL p_fall_e5: got %h expected %h", bus2.o_fall, 4'h0); end
        bus2.i_data = 4'h3;
        repeat (3) tick();
        checks++; if (bus2.o_filt !== 4'h0) begin errors++; $display("FAIL p_filt_r3: got %h expected %h", bus2.o_filt, 4'h0); end
        tick();
        checks++; if (bus2.o_filt !== 4'h3) begin errors++; $display("FAIL p_filt_r4: got %h expected %h", bus2.o_filt, 4'h3); end
        checks++; if (bus2.o_rise !== 4'h3) begin errors++; $display("FAIL p_rise_r4: got %h expected %h", bus2.o_rise, 4'h3); end
    endtask

    initial begin
        rst1_n = 1'b0;
        rst2_n = 1'b0;
        bus1.i_data = 4'hA;
        bus2.i_data = 4'h0;
        test_reset();
        test_both_edges();
        test_rise();
        test_glitch();
        test_toggle();
        test_reset_mid();
        test_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_sync_filter.md
Name: multi_sync_filter

Overview:
- Parametrised, multi-channel successor to the two-flop synchroniser.
- Each channel goes through:
  - a synchroniser chain of configurable depth;
  - a per-channel stability (deglitch) filter;
  - registered rising- and falling-edge pulse detection.
- Sits at the boundary of the destination clock domain and accepts asynchronous, slowly changing level signals such as status flags, pins and handshake levels.
- Not for multi-bit buses that must stay coherent; those use Gray-coded pointers.

Parameters:
- WIDTH, 4: number of independent channels (>=1).
- STAGES, 2: synchroniser flops per channel (>=2).
- FILTER_LEN, 4: consecutive cycles the synchronised value must differ from the filtered value before the filtered output accepts it. Must be >=1; 1 means no filtering, only one register stage.
- RST_VAL, {WIDTH{1'b0}}: reset value of every synchroniser stage and of o_filt.

Ports:
- i_clk, input, 1: destination clock.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_data, input, WIDTH: asynchronous level inputs.
- o_sync, output, WIDTH: output of the last synchroniser stage (unfiltered).
- o_filt, output, WIDTH: debounced and filtered level.
- o_rise, output, WIDTH: one-cycle pulse when o_filt[k] goes 0->1.
- o_fall, output, WIDTH: one-cycle pulse when o_filt[k] goes 1->0.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - all sync stages = RST_VAL, so o_sync = RST_VAL;
  - o_filt = RST_VAL;
  - all filter counters = 0;
  - o_rise = o_fall = 0.
- Release of reset is taken synchronously at the next i_clk edge. The block does not synchronise reset itself; the reset synchroniser lives at top level.
- Sync chain, per channel:
  - stage[0] <= i_data[k];
  - stage[n] <= stage[n-1];
  - o_sync[k] = stage[STAGES-1].
  - No logic between stages.
- Filter, per channel k, with counter cnt_k of width max(1, clog2(FILTER_LEN)). On each edge:
  - if o_sync[k] == o_filt[k]: cnt_k <= 0.
  - else if cnt_k == FILTER_LEN-1: o_filt[k] <= o_sync[k], cnt_k <= 0.
  - else: cnt_k <= cnt_k + 1.
- Glitch rejection: a difference lasting fewer than FILTER_LEN consecutive cycles at o_sync never reaches o_filt, and no pulse is generated. Any cycle of agreement restarts the count from 0.
- Edge pulses:
  - o_rise[k] and o_fall[k] are registered and are asserted in the same cycle o_filt[k] changes.
  - Width is exactly one cycle.
  - Never both high on one channel.
- Latency, from the first i_clk edge that samples a new stable i_data value (edge 0):
  - o_sync changes after edge STAGES;
  - o_filt, o_rise and o_fall change after edge STAGES+FILTER_LEN.
- Channels are fully independent. Simultaneous changes on several bits give independent, possibly same-cycle, pulses.
- Input toggling at a period shorter than FILTER_LEN cycles: o_filt holds its last accepted value indefinitely.
- Reset mid-count: counters are cleared and no partial count survives. The full latency applies again after release.
- Pulses are never generated by reset or by reset release, even when RST_VAL differs from the current i_data.

Test Plan:
- Default params, reset asserted with i_data=4'hA:
  - during reset, o_sync=o_filt=4'h0, o_rise=o_fall=0;
  - after release, o_sync=4'hA after 2 edges;
  - o_filt=4'hA and o_rise=4'hA for exactly 1 cycle after edge 6.
- Default params, i_data 4'h0 -> 4'h1 held:
  - o_sync[0]=1 after edge 2;
  - o_filt[0]=1 and o_rise[0]=1 after edge 6;
  - o_rise=0 from the following cycle.
- Default params, 3-cycle pulse on i_data[1]:
  - o_sync[1] shows a 3-cycle pulse;
  - o_filt stays 4'h0, and o_rise and o_fall never assert.
- Default params, o_filt=4'hA, then i_data -> 4'h5:
  - after edge 6, o_filt=4'h5, o_rise=4'h5 and o_fall=4'hA in the same cycle, both for 1 cycle.
- Default params, i_data 0->1 on bit2, reset pulsed 2 cycles after o_sync[2] rises:
  - all outputs return to 0 immediately;
  - after release, the full 6-edge latency applies before o_filt[2]=1.
- STAGES=3, FILTER_LEN=1, RST_VAL=4'hF, i_data=4'h0 after release:
  - o_sync=4'h0 after edge 3;
  - o_filt=4'h0 and o_fall=4'hF for 1 cycle after edge 4.
